// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Fetch-side next-PC stage. It owns the architectural fetch PC, resolves
//   branch/JAL/JALR redirects coming from EX, checks target alignment and
//   raises flushes. A redirect that arrives during a fetch stall is parked
//   and applied when the stall clears. It also counts the redirects that
//   are actually applied.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   stall            : fetch stall, PC holds while set
//   ex_valid         : EX-stage instruction valid
//   ex_is_branch/jal/jalr, ex_branch : control-transfer type and compare result
//   ex_pc, ex_imm, ex_rs1 : operands for target and link computation
//   pc               : current fetch PC
//   link_addr        : ex_pc + 4 (combinational)
//   flush            : kill IF/ID (combinational, equals take)
//   trap_misaligned  : one-cycle pulse on a misaligned taken target
//   trap_tval        : offending target, held until the next trap
//   taken_count      : wrapping count of applied aligned redirects
module pc_redirect_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter bit          IALIGN16     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        flush,
    output logic        trap_misaligned,
    output logic [31:0] trap_tval,
    output logic [31:0] taken_count
);

    typedef enum logic {
        RUN,
        PEND
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_ok_q, pend_ok_d;
    logic [31:0] count_q, count_d;
    logic        trap_q, trap_d;
    logic [31:0] tval_q, tval_d;

    logic        take;
    logic        misaligned;
    logic [31:0] target;
    logic [31:0] redir_pc;
    logic        redir_ok;

    // Target resolution; jalr has priority over jal/branch if flags overlap.
    always_comb begin
        take = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & ex_branch));
        if (ex_is_jalr) begin
            target = (ex_rs1 + ex_imm) & ~32'h1;
        end else begin
            target = ex_pc + ex_imm;
        end
        if (IALIGN16) begin
            misaligned = take & target[0];
        end else begin
            misaligned = take & (|target[1:0]);
        end
        // A misaligned redirect still redirects, but to the trap vector and
        // without counting as a taken transfer.
        redir_pc = misaligned ? TRAP_VECTOR : target;
        redir_ok = ~misaligned;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_ok_d = pend_ok_q;
        count_d   = count_q;
        tval_d    = tval_q;
        // The trap pulse fires on the take itself, even if the PC update is
        // deferred by a stall.
        trap_d    = misaligned;
        if (misaligned) begin
            tval_d = target;
        end

        case (state_q)
            RUN: begin
                if (take) begin
                    if (stall) begin
                        pend_d    = redir_pc;
                        pend_ok_d = redir_ok;
                        state_d   = PEND;
                    end else begin
                        pc_d = redir_pc;
                        if (redir_ok) begin
                            count_d = count_q + 32'd1;
                        end
                    end
                end else if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            PEND: begin
                if (stall) begin
                    if (take) begin
                        pend_d    = redir_pc;
                        pend_ok_d = redir_ok;
                    end
                end else begin
                    // A new take in the release cycle supersedes the parked one.
                    state_d = RUN;
                    if (take) begin
                        pc_d = redir_pc;
                        if (redir_ok) begin
                            count_d = count_q + 32'd1;
                        end
                    end else begin
                        pc_d = pend_q;
                        if (pend_ok_q) begin
                            count_d = count_q + 32'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_VECTOR;
            pend_q    <= '0;
            pend_ok_q <= 1'b0;
            count_q   <= '0;
            trap_q    <= 1'b0;
            tval_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_ok_q <= pend_ok_d;
            count_q   <= count_d;
            trap_q    <= trap_d;
            tval_q    <= tval_d;
        end
    end

    assign pc              = pc_q;
    assign link_addr       = ex_pc + 32'd4;
    assign flush           = take;
    assign trap_misaligned = trap_q;
    assign trap_tval       = tval_q;
    assign taken_count     = count_q;

endmodule
